// File: rtl/counter_pkg.sv
// Shared counter constants and the next-count rule, reused by the BCD display driver.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Widest supported count (16 bits) plus one bit of compare headroom.
  localparam int CNT_CW = 17;

  // Next count for one enabled step. bnd_o flags a boundary (terminal-count) event.
  function automatic logic [CNT_CW-1:0] cnt_next(
    input  logic [CNT_CW-1:0] cnt,
    input  logic [CNT_CW-1:0] max_val,
    input  logic              up,
    input  logic              sat,
    output logic              bnd_o
  );
    logic [CNT_CW-1:0] nxt;
    bnd_o = 1'b0;
    if (up) begin
      if (cnt >= max_val) begin
        bnd_o = 1'b1;
        nxt   = sat ? max_val : '0;
      end else begin
        nxt = cnt + 1'b1;
      end
    end else begin
      if (cnt == '0) begin
        bnd_o = 1'b1;
        nxt   = sat ? '0 : max_val;
      end else begin
        nxt = cnt - 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up/down event counter with load, wrap/saturate, terminal-count pulse and sticky ovf.
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SAT_MODE = CNT_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("mod_n_counter: WIDTH must be in 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("mod_n_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (SAT_MODE != CNT_WRAP && SAT_MODE != CNT_SAT) begin : g_bad_mode
    $error("mod_n_counter: SAT_MODE must be 0 or 1");
  end

  // Compare at CNT_CW bits so MODULUS == 2**WIDTH never aliases to zero.
  localparam logic [CNT_CW-1:0] MAX_V = CNT_CW'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             bnd;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    bnd     = 1'b0;
    if (load) begin
      count_d = (CNT_CW'(load_val) > MAX_V) ? WIDTH'(MAX_V) : load_val;
    end else if (en) begin
      count_d = WIDTH'(cnt_next(CNT_CW'(count_q), MAX_V, up_dn, SAT_MODE == CNT_SAT, bnd));
      tc_d    = bnd;
    end
    // Set beats clear when both land in the same cycle.
    if (clr_ovf) ovf_d = 1'b0;
    if (tc_d)    ovf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
Parametrised modulo-N up/down event counter, the successor to the lab's single-input 4-bit count block. It counts qualified input events (en) and supports configurable width, modulus, direction, synchronous load and wrap or saturate mode. It reports boundary events as a one-cycle terminal-count pulse plus a sticky overflow flag. It sits between the input debouncer and the 7-segment/LED display logic of the lab boards.

Parameters:
WIDTH, 4, count register width in bits; legal range 2..16.
MODULUS, 10, number of count states (0..MODULUS-1); legal range 2..2**WIDTH; elaboration error outside range.
SAT_MODE, 0, 0 = wrap at boundary, 1 = saturate (hold) at boundary.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
en  input  1  count-enable; one step per clock cycle while high.
up_dn  input  1  1 = count up, 0 = count down; sampled only when en=1.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value loaded when load=1.
clr_ovf  input  1  synchronous clear of sticky ovf.
count  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, registered, one cycle per boundary event.
ovf  output  1  sticky boundary-event flag, registered.

Behaviour:
- Reset (reset=0, any time, including mid-count): count=0, tc=0, ovf=0 asynchronously; held while reset=0; first update on the first rising edge after reset deasserts.
- Priority per cycle: load > en > hold.
- load=1: count <= min(load_val, MODULUS-1). Out-of-range values clamp to MODULUS-1. tc=0 that cycle. en is ignored.
- en=1, up_dn=1, count<MODULUS-1: count <= count+1.
- en=1, up_dn=1, count==MODULUS-1 (boundary):
  - Wrap mode: count <= 0.
  - Saturate mode: count holds at MODULUS-1.
  - Both modes: tc <= 1.
- en=1, up_dn=0, count>0: count <= count-1.
- en=1, up_dn=0, count==0 (boundary):
  - Wrap mode: count <= MODULUS-1.
  - Saturate mode: count holds at 0.
  - Both modes: tc <= 1.
- tc is high for exactly the cycle in which count shows its post-boundary value. With en held high at a saturated boundary, tc stays high every cycle.
- en=0 and load=0: count holds, tc <= 0.
- ovf set rules:
  - ovf <= 1 on any cycle in which tc is being set.
  - clr_ovf=1 clears ovf.
  - Simultaneous set and clear: set wins, so ovf=1.
- Arithmetic: use WIDTH+1-bit internal compare. The MODULUS==2**WIDTH case must wrap without overflow artefacts.
- Latency: one clock from en/load to count/tc/ovf. No combinational input-to-output paths.

Decomposition:
- Shared package counter_pkg: constants CNT_WRAP=0 and CNT_SAT=1, plus a function computing the next count value (shared with the planned BCD display driver).
- No sub-module. Single flat module with one registered always block and one combinational next-state block.

Test Plan:
- Reset mid-operation: count=7, assert reset=0 between clock edges -> count=0, tc=0, ovf=0 immediately; with en=1 after release, the first edge gives count=1.
- Wrap up (defaults): en=1, up_dn=1 for 10 cycles from 0 -> count 1..9 then 0; tc=1 only in the cycle count=0; ovf=1 afterwards.
- Wrap down: from count=0, en=1, up_dn=0 -> count=9, tc=1; next cycle count=8, tc=0.
- Saturate (SAT_MODE=1, WIDTH=4, MODULUS=16): count=15, en=1, up_dn=1 for 3 cycles -> count stays 15, tc=1 for all 3 cycles; then up_dn=0 -> count=14, tc=0.
- Load priority and clamp: load=1, load_val=12, en=1 (MODULUS=10) -> count=9, tc=0; next cycle load=0, en=1, up_dn=1 -> count=0, tc=1.
- ovf set/clear race: at a boundary event with clr_ovf=1 in the same cycle -> ovf=1; next cycle clr_ovf=1, en=0 -> ovf=0.
